// File: rtl/spu_issue_scheduler.sv
// spu_issue_scheduler: holds one decoded instruction pair, checks it against a
// per-register latency scoreboard and dual- or single-issues it to the SPU pipes.
module spu_issue_scheduler #(
  parameter int NREGS = 128,
  parameter int REG_W = 7,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [31:0]      i1_instr,
  input  logic             i1_even,
  input  logic [LAT_W-1:0] i1_lat,
  input  logic [REG_W-1:0] i1_ra,
  input  logic [REG_W-1:0] i1_rb,
  input  logic [REG_W-1:0] i1_rc,
  input  logic [2:0]       i1_use,
  input  logic             i1_wr,
  input  logic [REG_W-1:0] i1_rt,
  input  logic [31:0]      i2_instr,
  input  logic             i2_even,
  input  logic [LAT_W-1:0] i2_lat,
  input  logic [REG_W-1:0] i2_ra,
  input  logic [REG_W-1:0] i2_rb,
  input  logic [REG_W-1:0] i2_rc,
  input  logic [2:0]       i2_use,
  input  logic             i2_wr,
  input  logic [REG_W-1:0] i2_rt,
  output logic             even_valid,
  output logic [31:0]      even_instr,
  output logic             odd_valid,
  output logic [31:0]      odd_instr,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, BOTH, SECOND} state_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic             even;
    logic [LAT_W-1:0] lat;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [2:0]       umask;
    logic             wr;
    logic [REG_W-1:0] rt;
  } instr_t;

  state_t           state, state_next;
  instr_t           in1, in2, h1, h2;
  logic [LAT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] busy;
  logic             accept, issue1, issue2;
  logic             rdy1, rdy2, hazard2;

  assign in1 = {i1_instr, i1_even, i1_lat, i1_ra, i1_rb, i1_rc, i1_use, i1_wr, i1_rt};
  assign in2 = {i2_instr, i2_even, i2_lat, i2_ra, i2_rb, i2_rc, i2_use, i2_wr, i2_rt};

  function automatic logic reads_reg(instr_t i, logic [REG_W-1:0] r);
    return (i.umask[0] && i.ra == r) || (i.umask[1] && i.rb == r) ||
           (i.umask[2] && i.rc == r);
  endfunction

  function automatic logic is_rdy(instr_t i, logic [NREGS-1:0] b);
    return !((i.umask[0] && b[i.ra]) || (i.umask[1] && b[i.rb]) ||
             (i.umask[2] && b[i.rc]) || (i.wr && b[i.rt]));
  endfunction

  // A latency of 0 behaves like 1: the result is usable the very next cycle.
  function automatic logic [LAT_W-1:0] load_val(logic [LAT_W-1:0] lat);
    return (lat == '0) ? '0 : lat - 1'b1;
  endfunction

  always_comb begin
    for (int r = 0; r < NREGS; r++) busy[r] = (cnt[r] != '0);
  end

  assign in_ready = (state == IDLE) && !flush;

  // instr2 is held back by real hazards only; a pipe conflict alone is not a stall.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue1     = 1'b0;
    issue2     = 1'b0;
    stall      = 1'b0;
    rdy1       = is_rdy(h1, busy);
    rdy2       = is_rdy(h2, busy);
    hazard2    = !rdy2 || (h1.wr && reads_reg(h2, h1.rt)) ||
                 (h1.wr && h2.wr && h1.rt == h2.rt);
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept     = 1'b1;
          state_next = BOTH;
        end
      end
      BOTH: begin
        if (flush) begin
          state_next = IDLE;
        end else if (!rdy1) begin
          stall = 1'b1;
        end else begin
          issue1 = 1'b1;
          if ((h1.even != h2.even) && !hazard2) begin
            issue2     = 1'b1;
            state_next = IDLE;
          end else begin
            stall      = hazard2;
            state_next = SECOND;
          end
        end
      end
      SECOND: begin
        if (flush) begin
          state_next = IDLE;
        end else if (rdy2) begin
          issue2     = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      h1         <= '0;
      h2         <= '0;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      even_instr <= '0;
      odd_instr  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        h1 <= in1;
        h2 <= in2;
      end
      even_valid <= (issue1 && h1.even) || (issue2 && h2.even);
      odd_valid  <= (issue1 && !h1.even) || (issue2 && !h2.even);
      if (issue1) begin
        if (h1.even) even_instr <= h1.instr;
        else         odd_instr  <= h1.instr;
      end
      if (issue2) begin
        if (h2.even) even_instr <= h2.instr;
        else         odd_instr  <= h2.instr;
      end
    end
  end

  // Issue loads override the per-cycle decrement; a dual issue never targets one rt twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
      if (issue1 && h1.wr) cnt[h1.rt] <= load_val(h1.lat);
      if (issue2 && h2.wr) cnt[h2.rt] <= load_val(h2.lat);
    end
  end

endmodule

// File: tb/tb_spu_issue_scheduler.sv
// tb_spu_issue_scheduler: directed and random pairs checked against a
// transaction-level model that tracks the cycle at which each register frees up.
module tb_spu_issue_scheduler;

  localparam int NREGS = 128;
  localparam int REG_W = 7;
  localparam int LAT_W = 4;
  localparam int NEVER = 1000000;

  typedef struct {
    logic [31:0]      instr;
    logic             even;
    logic [LAT_W-1:0] lat;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [2:0]       umask;
    logic             wr;
    logic [REG_W-1:0] rt;
  } ins_t;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush;
  logic [31:0]      i1_instr, i2_instr;
  logic             i1_even, i2_even, i1_wr, i2_wr;
  logic [LAT_W-1:0] i1_lat, i2_lat;
  logic [REG_W-1:0] i1_ra, i1_rb, i1_rc, i1_rt, i2_ra, i2_rb, i2_rc, i2_rt;
  logic [2:0]       i1_use, i2_use;
  logic             even_valid, odd_valid, stall;
  logic [31:0]      even_instr, odd_instr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ready_at [NREGS];
  logic        carry_ev, carry_ov;
  logic [31:0] carry_ei, carry_oi;

  always #5 clk = ~clk;

  spu_issue_scheduler #(.NREGS(NREGS), .REG_W(REG_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .i1_instr(i1_instr), .i1_even(i1_even), .i1_lat(i1_lat), .i1_ra(i1_ra),
    .i1_rb(i1_rb), .i1_rc(i1_rc), .i1_use(i1_use), .i1_wr(i1_wr), .i1_rt(i1_rt),
    .i2_instr(i2_instr), .i2_even(i2_even), .i2_lat(i2_lat), .i2_ra(i2_ra),
    .i2_rb(i2_rb), .i2_rc(i2_rc), .i2_use(i2_use), .i2_wr(i2_wr), .i2_rt(i2_rt),
    .even_valid(even_valid), .even_instr(even_instr),
    .odd_valid(odd_valid), .odd_instr(odd_instr), .stall(stall)
  );

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic ins_t mk(input logic [31:0] instr, input bit even, input int lat,
                              input int ra, input int rb, input int rc, input int um,
                              input bit wr, input int rt);
    ins_t p;
    p.instr = instr;
    p.even  = even;
    p.lat   = LAT_W'(lat);
    p.ra    = REG_W'(ra);
    p.rb    = REG_W'(rb);
    p.rc    = REG_W'(rc);
    p.umask = 3'(um);
    p.wr    = wr;
    p.rt    = REG_W'(rt);
    return p;
  endfunction

  function automatic ins_t rand_ins(input int nreg);
    return mk($urandom, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
              int'($urandom_range(nreg - 1, 0)), int'($urandom_range(nreg - 1, 0)),
              int'($urandom_range(nreg - 1, 0)), int'($urandom_range(7, 0)),
              1'($urandom_range(1, 0)), int'($urandom_range(nreg - 1, 0)));
  endfunction

  // A register written at decision cycle c with latency L is readable from c+max(L,1).
  function automatic bit is_free(input ins_t p, input int c);
    if (p.umask[0] && ready_at[p.ra] > c) return 1'b0;
    if (p.umask[1] && ready_at[p.rb] > c) return 1'b0;
    if (p.umask[2] && ready_at[p.rc] > c) return 1'b0;
    if (p.wr && ready_at[p.rt] > c) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int eff_lat(input logic [LAT_W-1:0] lat);
    return (lat == 0) ? 1 : int'(lat);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_stimulus(input logic v, input ins_t p1, input ins_t p2,
                                input logic fl, input logic rst);
    in_valid = v;
    flush    = fl;
    reset    = rst;
    i1_instr = p1.instr; i1_even = p1.even; i1_lat = p1.lat; i1_ra = p1.ra;
    i1_rb = p1.rb; i1_rc = p1.rc; i1_use = p1.umask; i1_wr = p1.wr; i1_rt = p1.rt;
    i2_instr = p2.instr; i2_even = p2.even; i2_lat = p2.lat; i2_ra = p2.ra;
    i2_rb = p2.rb; i2_rc = p2.rc; i2_use = p2.umask; i2_wr = p2.wr; i2_rt = p2.rt;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic ev, input logic [31:0] ei,
                              input logic ov, input logic [31:0] oi,
                              input logic st, input logic rd);
    @(negedge clk);
    check_val({tag, ".even_valid"}, 32'(even_valid), 32'(ev));
    check_val({tag, ".odd_valid"},  32'(odd_valid),  32'(ov));
    check_val({tag, ".stall"},      32'(stall),      32'(st));
    check_val({tag, ".in_ready"},   32'(in_ready),   32'(rd));
    if (ev) check_val({tag, ".even_instr"}, even_instr, ei);
    if (ov) check_val({tag, ".odd_instr"},  odd_instr,  oi);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, rand_ins(NREGS), rand_ins(NREGS), 1'b0, 1'b0);
    check_output("idle", carry_ev, carry_ei, carry_ov, carry_oi, 1'b0, 1'b1);
    carry_ev = 1'b0;
    carry_ov = 1'b0;
    tick();
  endtask

  // Offers one pair at the current cycle and walks it to completion; offsets of 0 mean
  // no flush / no reset, otherwise they name the cycle after acceptance to assert it.
  task automatic run_pair(input string tag, input ins_t p1, input ins_t p2,
                          input int flush_off, input int reset_off);
    int a, c1, c2, f, rs, end_c;
    bit raw, waw, haz2, dual, iss1, iss2;
    logic ev, ov, st, rd;
    logic [31:0] ei, oi;
    a  = cyc;
    f  = (flush_off > 0) ? a + flush_off : NEVER;
    rs = (reset_off > 0) ? a + reset_off : NEVER;
    c1 = a + 1;
    while (!is_free(p1, c1)) c1++;
    raw  = p1.wr && ((p2.umask[0] && p2.ra == p1.rt) || (p2.umask[1] && p2.rb == p1.rt) ||
                     (p2.umask[2] && p2.rc == p1.rt));
    waw  = p1.wr && p2.wr && (p1.rt == p2.rt);
    haz2 = !is_free(p2, c1) || raw || waw;
    dual = (p1.even != p2.even) && !haz2;
    iss1 = (c1 < f) && (c1 < rs);
    c2   = c1;
    if (iss1) begin
      if (p1.wr) ready_at[p1.rt] = c1 + eff_lat(p1.lat);
      if (!dual) begin
        c2 = c1 + 1;
        while (!is_free(p2, c2)) c2++;
      end
    end
    iss2 = iss1 && (c2 < f) && (c2 < rs);
    if (iss2 && p2.wr) ready_at[p2.rt] = c2 + eff_lat(p2.lat);
    end_c = iss2 ? c2 : ((f < rs) ? f : rs);

    for (int c = a; c <= end_c; c++) begin
      apply_stimulus(c == a, (c == a) ? p1 : rand_ins(NREGS), (c == a) ? p2 : rand_ins(NREGS),
                     c == f, c == rs);
      ev = 1'b0; ov = 1'b0; ei = '0; oi = '0;
      if (c == a) begin
        ev = carry_ev; ei = carry_ei; ov = carry_ov; oi = carry_oi;
      end else if (iss1 && c == c1 + 1) begin
        if (p1.even) begin ev = 1'b1; ei = p1.instr; end
        else         begin ov = 1'b1; oi = p1.instr; end
        if (dual) begin
          if (p2.even) begin ev = 1'b1; ei = p2.instr; end
          else         begin ov = 1'b1; oi = p2.instr; end
        end
      end
      if (c == a || c == f)  st = 1'b0;
      else if (c < c1)       st = 1'b1;
      else if (c == c1)      st = dual ? 1'b0 : haz2;
      else if (c < c2)       st = 1'b1;
      else                   st = 1'b0;
      rd = (c == a);
      if (c != rs) check_output(tag, ev, ei, ov, oi, st, rd);
      tick();
    end

    carry_ev = 1'b0;
    carry_ov = 1'b0;
    if (end_c == rs) begin
      for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
    end else if (iss2) begin
      if (dual) begin
        if (p1.even) begin carry_ev = 1'b1; carry_ei = p1.instr; end
        else         begin carry_ov = 1'b1; carry_oi = p1.instr; end
      end
      if (p2.even) begin carry_ev = 1'b1; carry_ei = p2.instr; end
      else         begin carry_ov = 1'b1; carry_oi = p2.instr; end
    end
  endtask

  initial begin
    int fo, ro;
    for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
    carry_ev = 1'b0; carry_ov = 1'b0; carry_ei = '0; carry_oi = '0;
    apply_stimulus(1'b0, rand_ins(NREGS), rand_ins(NREGS), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(1'b0, rand_ins(NREGS), rand_ins(NREGS), 1'b0, 1'b0);
    check_output("reset", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check_val("reset.even_instr", even_instr, 32'h0);
    check_val("reset.odd_instr",  odd_instr,  32'h0);
    tick();

    $display("[TB] independent pair dual-issues");
    run_pair("dual", mk(32'h1000_0003, 1, 2, 0, 0, 0, 0, 1, 3),
                     mk(32'h2000_0005, 0, 3, 0, 0, 0, 0, 1, 5), 0, 0);
    idle_cycle();

    $display("[TB] same-pipe pair issues in order without stall");
    run_pair("same_pipe", mk(32'h1100_000a, 1, 1, 0, 0, 0, 0, 1, 10),
                          mk(32'h1200_000b, 1, 1, 0, 0, 0, 0, 1, 11), 0, 0);
    idle_cycle();

    $display("[TB] RAW across the pair waits for producer latency");
    run_pair("raw", mk(32'h1300_0007, 1, 4, 0, 0, 0, 0, 1, 7),
                    mk(32'h2300_0007, 0, 1, 7, 0, 0, 1, 0, 0), 0, 0);
    idle_cycle();

    $display("[TB] instr1 blocked by scoreboard, then dual-issue");
    run_pair("sb_setup", mk(32'h1400_0009, 1, 5, 0, 0, 0, 0, 1, 9),
                         mk(32'h2400_000c, 0, 1, 0, 0, 0, 0, 1, 12), 0, 0);
    run_pair("sb_block", mk(32'h1500_0009, 1, 1, 9, 0, 0, 1, 0, 0),
                         mk(32'h2500_0000, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    idle_cycle();

    $display("[TB] flush while instr2 is held");
    run_pair("flush", mk(32'h1600_0014, 1, 6, 0, 0, 0, 0, 1, 20),
                      mk(32'h2600_0014, 0, 1, 20, 0, 0, 1, 0, 0), 2, 0);
    run_pair("post_flush", mk(32'h1700_0014, 1, 1, 20, 0, 0, 1, 0, 0),
                           mk(32'h2700_0000, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    idle_cycle();

    $display("[TB] reset while pair blocked in BOTH");
    run_pair("rst_setup", mk(32'h1800_0003, 1, 7, 0, 0, 0, 0, 1, 3),
                          mk(32'h2800_0000, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    run_pair("rst_hit", mk(32'h1900_0003, 1, 1, 3, 0, 0, 1, 0, 0),
                        mk(32'h2900_0000, 0, 1, 0, 0, 0, 0, 0, 0), 0, 1);
    run_pair("post_rst", mk(32'h1a00_0003, 1, 1, 3, 0, 0, 1, 0, 0),
                         mk(32'h2a00_0003, 0, 1, 0, 3, 0, 2, 0, 0), 0, 0);
    idle_cycle();

    $display("[TB] random pairs");
    for (int n = 0; n < 80; n++) begin
      fo = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      ro = ($urandom_range(19, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      run_pair("rand", rand_ins(6), rand_ins(6), fo, ro);
      if ($urandom_range(3, 0) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
